ray_pixel_sequencer: RTL and testbench
======================================

// Module: ray_pixel_sequencer
// PURPOSE
//  Drives the ray-trace core's pixel input: walks the screen in raster order, one Pixel_s per job.
//  Waits the core's fixed latency, then samples less_than_zero.
//  Turns the result into a 1-bit hit/miss word and writes it to the framebuffer via valid/ready.
//  Sits between the frame controller (start/done) and the core + framebuffer write port.
// PARAMETERS
//  H_RES         640  pixels per line (x range 0..H_RES-1)
//  V_RES         480  lines per frame (y range 0..V_RES-1)
//  Z_PLANE       31   constant z driven on pixel.z for every job
//  CORE_LATENCY  4    clk cycles from pixel stable to less_than_zero valid (>=1)
// PORTS
//  clk             in   1    system clock, all logic on rising edge
//  rst_n           in   1    synchronous active-low reset
//  start           in   1    1-cycle pulse: begin a frame (ignored unless IDLE)
//  pixel           out  Pixel_s  coordinate to core (x,y,z)
//  less_than_zero  in   1    core result: 1 = discriminant<0 = miss
//  fb_valid        out  1    framebuffer write request
//  fb_ready        in   1    framebuffer accepts when fb_valid&&fb_ready
//  fb_addr         out  19   linear address y*H_RES+x
//  fb_data         out  1    1 = hit (~less_than_zero)
//  busy            out  1    high in any state but IDLE
//  frame_done      out  1    1-cycle pulse after last write accepted
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, pixel={0,0,Z_PLANE}, fb_valid=0, fb_addr=0, fb_data=0,
//   busy=0, frame_done=0, counters cleared. Reset mid-frame aborts; no pending write completes.
//  FSM IDLE -> ISSUE -> WAIT -> WRITE -> (ISSUE | DONE) -> IDLE.
//  IDLE: on start: x=y=0, addr=0 -> ISSUE.
//  ISSUE (1 cyc): register pixel={x,y,Z_PLANE}. Load lat_cnt=CORE_LATENCY-1. -> WAIT.
//  WAIT: pixel held stable; lat_cnt decrements; at 0 capture fb_data=~less_than_zero, fb_valid=1 -> WRITE.
//  WRITE: fb_valid, fb_addr, fb_data held stable while fb_ready=0.
//   On handshake: fb_valid=0 in the next cycle.
//    If x==H_RES-1 && y==V_RES-1 -> DONE.
//    Else x++ (wrap to 0 with y++ at H_RES-1), addr++ -> ISSUE.
//  DONE (1 cyc): frame_done=1 -> IDLE.
//  Per-pixel cost: 1+CORE_LATENCY+1 cycles min (fb_ready tied high) = CORE_LATENCY+2.
//  fb_addr is maintained by incrementer, no multiplier. Addr wraps never; max H_RES*V_RES-1.
//  start while busy: ignored, no restart. start in same cycle as DONE: ignored.
//  fb_ready high outside WRITE: no effect.
// CONFIGURATION
//  RAY_SEQ_HIT_COUNT_EN defined:
//   adds out port hit_count[19:0]. Cleared on reset and on accepted start.
//   Increments on each accepted write with fb_data=1. Holds its value after frame_done until next start.
//  Undefined: port absent, no counter logic.
// STRUCTURE
//  Shared package (raytrace_pkg): Pixel_s, World_s, SCREEN_W/SCREEN_H, FB_ADDR_W=19,
//   seq_state_e enum.
//  One sub-module: raster_counter (x/y/addr counters with wrap and last flag); FSM stays in top.
// TESTING
//  1 Reset: hold rst_n=0 3 cyc, then release -> all outputs at reset values, busy=0.
//  2 H_RES=4,V_RES=2,CORE_LATENCY=3, fb_ready=1, core model lt0=(x==1) -> 8 writes:
//    addr 0..7, data 1,0,1,1,1,0,1,1; frame_done at cycle 40 after start (8*5).
//  3 fb_ready low 5 cyc in pixel 2's WRITE -> addr/data/valid stable, no extra or dropped write.
//  4 start pulsed mid-frame and in DONE cycle -> ignored, exactly H_RES*V_RES writes.
//  5 rst_n=0 during WAIT of pixel 3 -> IDLE next cycle, fb_valid=0, no write of pixel 3; new start restarts at addr 0.
//  6 RAY_SEQ_HIT_COUNT_EN, scenario 2 -> hit_count=6 at frame_done; cleared on next start.

Source files
------------

// File: rtl/raytrace_pkg.sv
// Shared types for the ray-trace pixel path: screen geometry, pixel/world structs, sequencer states.
package raytrace_pkg;

    localparam int unsigned SCREEN_W  = 640;
    localparam int unsigned SCREEN_H  = 480;
    localparam int unsigned COORD_W   = 10;
    localparam int unsigned FB_ADDR_W = 19;
    localparam int unsigned HIT_CNT_W = 20;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
    } Pixel_s;

    typedef struct packed {
        Pixel_s             center;
        logic [COORD_W-1:0] radius;
    } World_s;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StWrite,
        StDone
    } seq_state_e;

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y walker with a linear framebuffer address kept by increment (no multiply).
module raster_counter
    import raytrace_pkg::*;
#(
    parameter int unsigned H_RES = SCREEN_W,
    parameter int unsigned V_RES = SCREEN_H
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 advance,
    output logic [COORD_W-1:0]   x,
    output logic [COORD_W-1:0]   y,
    output logic [FB_ADDR_W-1:0] addr,
    output logic                 last
);

    logic x_end;

    assign x_end = (x == COORD_W'(H_RES - 1));
    assign last  = x_end && (y == COORD_W'(V_RES - 1));

    // Holds on the final pixel so the address never wraps past H_RES*V_RES-1.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (advance && !last) begin
            addr <= addr + FB_ADDR_W'(1);
            if (x_end) begin
                x <= '0;
                y <= y + COORD_W'(1);
            end else begin
                x <= x + COORD_W'(1);
            end
        end
    end

endmodule

// File: rtl/ray_pixel_sequencer.sv
// Feeds raster-order pixels to the ray core and writes its hit/miss results to the framebuffer.
// Optional RAY_SEQ_HIT_COUNT_EN adds a per-frame hit counter output.
module ray_pixel_sequencer
    import raytrace_pkg::*;
#(
    parameter int unsigned H_RES        = SCREEN_W,
    parameter int unsigned V_RES        = SCREEN_H,
    parameter int unsigned Z_PLANE      = 31,
    parameter int unsigned CORE_LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output Pixel_s               pixel,
    input  logic                 less_than_zero,
    output logic                 fb_valid,
    input  logic                 fb_ready,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic                 fb_data,
    output logic                 busy,
    output logic                 frame_done
`ifdef RAY_SEQ_HIT_COUNT_EN
    ,
    output logic [HIT_CNT_W-1:0] hit_count
`endif
);

    localparam int unsigned LAT_W = (CORE_LATENCY > 1) ? $clog2(CORE_LATENCY) : 1;

    seq_state_e         state, state_next;
    logic [LAT_W-1:0]   lat_cnt;
    logic [COORD_W-1:0] x, y;
    logic               last, clear, advance, handshake;

    raster_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_raster (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .advance (advance),
        .x       (x),
        .y       (y),
        .addr    (fb_addr),
        .last    (last)
    );

    assign handshake  = (state == StWrite) && fb_ready;
    assign fb_valid   = (state == StWrite);
    assign busy       = (state != StIdle);
    assign frame_done = (state == StDone);

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        advance    = 1'b0;
        case (state)
            StIdle: begin
                if (start) begin
                    clear      = 1'b1;
                    state_next = StIssue;
                end
            end
            StIssue: state_next = StWait;
            StWait: begin
                if (lat_cnt == '0) state_next = StWrite;
            end
            StWrite: begin
                if (handshake) begin
                    advance    = 1'b1;
                    state_next = last ? StDone : StIssue;
                end
            end
            StDone:  state_next = StIdle;
            default: state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= StIdle;
            pixel   <= '{x: '0, y: '0, z: COORD_W'(Z_PLANE)};
            lat_cnt <= '0;
            fb_data <= 1'b0;
        end else begin
            state <= state_next;
            if (state == StIssue) begin
                pixel   <= '{x: x, y: y, z: COORD_W'(Z_PLANE)};
                lat_cnt <= LAT_W'(CORE_LATENCY - 1);
            end else if (state == StWait && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end
            // Core reports miss; framebuffer stores hit.
            if (state == StWait && lat_cnt == '0) fb_data <= ~less_than_zero;
        end
    end

`ifdef RAY_SEQ_HIT_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_count <= '0;
        end else if (state == StIdle && start) begin
            hit_count <= '0;
        end else if (handshake && fb_data) begin
            hit_count <= hit_count + HIT_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ray_pixel_sequencer.sv
// Randomised bench for ray_pixel_sequencer against a job-level timing/result model.
// Honours RAY_SEQ_HIT_COUNT_EN when defined.
module tb_ray_pixel_sequencer;
    import raytrace_pkg::*;

    localparam int H   = 4;
    localparam int V   = 2;
    localparam int ZP  = 31;
    localparam int LAT = 3;
    localparam int N   = H * V;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 fb_ready = 1'b1;
    logic                 less_than_zero;
    Pixel_s               pixel;
    logic                 fb_valid;
    logic [FB_ADDR_W-1:0] fb_addr;
    logic                 fb_data;
    logic                 busy;
    logic                 frame_done;
`ifdef RAY_SEQ_HIT_COUNT_EN
    logic [HIT_CNT_W-1:0] hit_count;
`endif

    ray_pixel_sequencer #(
        .H_RES        (H),
        .V_RES        (V),
        .Z_PLANE      (ZP),
        .CORE_LATENCY (LAT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .pixel          (pixel),
        .less_than_zero (less_than_zero),
        .fb_valid       (fb_valid),
        .fb_ready       (fb_ready),
        .fb_addr        (fb_addr),
        .fb_data        (fb_data),
        .busy           (busy),
        .frame_done     (frame_done)
`ifdef RAY_SEQ_HIT_COUNT_EN
        ,
        .hit_count      (hit_count)
`endif
    );

    always #5 clk = ~clk;

    // Core stand-in: miss flag per screen position.
    bit lt_tab [N];
    always_comb begin
        less_than_zero = 1'b0;
        if (int'(pixel.x) < H && int'(pixel.y) < V)
            less_than_zero = lt_tab[int'(pixel.y) * H + int'(pixel.x)];
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_edge = 0;
    int done_edge = -1;
    int dut_writes = 0;
    int wr_addr_q[$];
    bit wr_data_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Model: a job becomes a visible write LAT+1 edges after start/previous handshake;
    // frame_done follows the last handshake for one cycle.
    bit     m_busy, m_valid, m_done, m_fresh;
    int     m_wait, m_idx, m_hits;
    Pixel_s exp_px;

    always @(posedge clk) begin
        if (rst_n === 1'b1 && fb_valid === 1'b1 && fb_ready === 1'b1) begin
            dut_writes++;
            wr_addr_q.push_back(int'(fb_addr));
            wr_data_q.push_back(fb_data);
        end
        cyc++;
        if (!rst_n) begin
            m_busy = 0; m_valid = 0; m_done = 0; m_idx = 0; m_hits = 0; m_fresh = 1;
        end else if (m_done) begin
            m_done = 0; m_busy = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1; m_idx = 0; m_wait = LAT + 1; m_hits = 0; m_fresh = 0;
                start_edge = cyc;
            end
        end else if (m_valid) begin
            if (fb_ready) begin
                m_valid = 0;
                if (!lt_tab[m_idx]) m_hits++;
                if (m_idx == N - 1) m_done = 1;
                else begin
                    m_idx++;
                    m_wait = LAT + 1;
                end
            end
        end else begin
            m_wait--;
            if (m_wait == 0) m_valid = 1;
        end
        #1;
        check("busy", 64'(busy), 64'(m_busy));
        check("fb_valid", 64'(fb_valid), 64'(m_valid));
        check("frame_done", 64'(frame_done), 64'(m_done));
        if (m_fresh) begin
            exp_px = '{x: '0, y: '0, z: COORD_W'(ZP)};
            check("reset_pixel", 64'(pixel), 64'(exp_px));
            check("reset_fb_addr", 64'(fb_addr), 64'd0);
            check("reset_fb_data", 64'(fb_data), 64'd0);
        end
        if (m_busy) check("fb_addr", 64'(fb_addr), 64'(m_idx));
        if (m_busy && !m_done && (m_valid || m_wait <= LAT)) begin
            exp_px = '{x: COORD_W'(m_idx % H), y: COORD_W'(m_idx / H), z: COORD_W'(ZP)};
            check("pixel", 64'(pixel), 64'(exp_px));
        end
        if (m_valid) check("fb_data", 64'(fb_data), 64'(!lt_tab[m_idx]));
`ifdef RAY_SEQ_HIT_COUNT_EN
        check("hit_count", 64'(hit_count), 64'(m_hits));
`endif
        if (frame_done === 1'b1) done_edge = cyc;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (frame_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (frame_done !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout got=no_frame_done expected=frame_done_within_%0d", name, budget);
        end
    endtask

    task automatic wait_cond_pixel3(input int budget);
        int n = 0;
        while (!(busy === 1'b1 && fb_valid === 1'b0 && int'(pixel.x) == 3 && int'(pixel.y) == 0)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            failures++;
            $display("FAIL s5_wait_timeout got=no_pixel3_wait expected=within_%0d", budget);
        end
    endtask

    initial begin
        logic [7:0] exp_d;
        int         w0, n;
        for (int i = 0; i < N; i++) lt_tab[i] = ((i % H) == 1);

        // 1: reset
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("s1_busy", 64'(busy), 64'd0);
        check("s1_fb_valid", 64'(fb_valid), 64'd0);
        check("s1_pixel", 64'(pixel), 64'({10'd0, 10'd0, 10'd31}));

        // 2: nominal frame, literal results
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        wait_done(200, "s2");
        exp_d = 8'b1101_1101;
        check("s2_nwrites", 64'(wr_addr_q.size()), 64'd8);
        for (int i = 0; i < 8 && i < wr_addr_q.size(); i++) begin
            check("s2_addr", 64'(wr_addr_q[i]), 64'(i));
            check("s2_data", 64'(wr_data_q[i]), 64'(exp_d[i]));
        end
        check("s2_done_cycle", 64'(done_edge - start_edge), 64'd40);
`ifdef RAY_SEQ_HIT_COUNT_EN
        check("s6_hits", 64'(hit_count), 64'd6);
`endif
        @(negedge clk);

        // 3: stall pixel 2's write
        w0 = dut_writes;
        pulse_start();
        n = 0;
        while (!(fb_valid === 1'b1 && int'(fb_addr) == 2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("s3_reached_px2", 64'(fb_valid === 1'b1 && int'(fb_addr) == 2), 64'd1);
        fb_ready = 1'b0;
        repeat (5) @(negedge clk);
        fb_ready = 1'b1;
        wait_done(200, "s3");
        check("s3_nwrites", 64'(dut_writes - w0), 64'(N));
        @(negedge clk);

        // 4: start while busy and in the DONE cycle
        w0 = dut_writes;
        pulse_start();
        repeat (3) begin
            repeat ($urandom_range(2, 8)) @(negedge clk);
            pulse_start();
        end
        wait_done(200, "s4");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("s4_idle_after_done", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check("s4_still_idle", 64'(busy), 64'd0);
        check("s4_nwrites", 64'(dut_writes - w0), 64'(N));

        // 5: reset during pixel 3 WAIT
        w0 = dut_writes;
        pulse_start();
        wait_cond_pixel3(100);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("s5_busy", 64'(busy), 64'd0);
        check("s5_fb_valid", 64'(fb_valid), 64'd0);
        check("s5_nwrites", 64'(dut_writes - w0), 64'd3);
        repeat (LAT + 3) @(negedge clk);
        check("s5_no_late_write", 64'(dut_writes - w0), 64'd3);
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        wait_done(200, "s5");
        check("s5_restart_nwrites", 64'(wr_addr_q.size()), 64'(N));
        if (wr_addr_q.size() > 0) check("s5_restart_addr0", 64'(wr_addr_q[0]), 64'd0);
        @(negedge clk);

        // Randomised frames: random hit map, backpressure and stray starts
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N; i++) lt_tab[i] = bit'($urandom_range(0, 1));
            w0 = dut_writes;
            pulse_start();
            n = 0;
            while (n < 400) begin
                if (frame_done === 1'b1) break;
                fb_ready = ($urandom_range(0, 3) != 0);
                start = ($urandom_range(0, 15) == 0);
                @(negedge clk);
                n++;
            end
            start = 1'b0;
            fb_ready = 1'b1;
            check("rand_frame_done_seen", 64'(frame_done), 64'd1);
            check("rand_nwrites", 64'(dut_writes - w0), 64'(N));
            repeat (2) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
